// File: rtl/vc_dest_router.sv
// Routes words popped from VC0/VC1 into D0/D1 by destination bit, with a 2-entry in-order hold buffer.
// Optional push counters are built when DEST_COUNT_EN is defined.
module vc_dest_router #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned DEST_BIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  VC0_rd,
  input  logic                  VC1_rd,
  input  logic                  vc0_delay,
  input  logic [DATA_WIDTH-1:0] VC0_data,
  input  logic [DATA_WIDTH-1:0] VC1_data,
  input  logic                  D0_full,
  input  logic                  D1_full,
  output logic                  D0_push,
  output logic                  D1_push,
  output logic [DATA_WIDTH-1:0] D0_data_out,
  output logic [DATA_WIDTH-1:0] D1_data_out,
  output logic                  hold_busy,
  output logic                  overflow_err,
  output logic [7:0]            D0_count,
  output logic [7:0]            D1_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} hold_state_t;

  hold_state_t           state_q, state_d;
  logic                  pend_valid, pend_sel;
  logic [DATA_WIDTH-1:0] new_word, cand;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  cand_valid, cand_dest, cand_full, do_push, ovf_set;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_valid <= 1'b0;
      pend_sel   <= 1'b0;
    end else begin
      pend_valid <= VC0_rd | VC1_rd;
      pend_sel   <= VC1_rd & ~VC0_rd;
    end
  end

  assign new_word  = pend_sel ? VC1_data : VC0_data;
  assign hold_busy = (state_q != EMPTY);

  // The hold head always takes priority over the arriving word, keeping order.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    ovf_set    = 1'b0;
    cand       = (state_q == EMPTY) ? new_word : head_q;
    cand_valid = (state_q != EMPTY) | pend_valid;
    cand_dest  = cand[DEST_BIT];
    cand_full  = cand_dest ? D1_full : D0_full;
    do_push    = cand_valid & ~cand_full;
    unique case (state_q)
      EMPTY: begin
        if (pend_valid && !do_push) begin
          state_d = ONE;
          head_d  = new_word;
        end
      end
      ONE: begin
        if (do_push) begin
          if (pend_valid) head_d  = new_word;
          else            state_d = EMPTY;
        end else if (pend_valid) begin
          state_d = TWO;
          tail_d  = new_word;
        end
      end
      TWO: begin
        if (do_push) begin
          head_d = tail_q;
          if (pend_valid) tail_d  = new_word;
          else            state_d = ONE;
        end else if (pend_valid) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      D0_push      <= 1'b0;
      D1_push      <= 1'b0;
      D0_data_out  <= '0;
      D1_data_out  <= '0;
      overflow_err <= 1'b0;
    end else begin
      D0_push <= do_push & ~cand_dest;
      D1_push <= do_push & cand_dest;
      if (do_push && !cand_dest) D0_data_out <= cand;
      if (do_push && cand_dest)  D1_data_out <= cand;
      if (ovf_set) overflow_err <= 1'b1;
    end
  end

`ifdef DEST_COUNT_EN
  logic [7:0] d0_cnt_q, d1_cnt_q;

  // Counted on the same edge that raises the push strobe.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d0_cnt_q <= '0;
      d1_cnt_q <= '0;
    end else begin
      if (do_push && !cand_dest) d0_cnt_q <= d0_cnt_q + 8'd1;
      if (do_push && cand_dest)  d1_cnt_q <= d1_cnt_q + 8'd1;
    end
  end

  assign D0_count = d0_cnt_q;
  assign D1_count = d1_cnt_q;
`else
  assign D0_count = '0;
  assign D1_count = '0;
`endif

  // vc0_delay is a cross-check of the arbiter's selection, never a selector.
  tie_check: assert property (@(posedge clk) disable iff (!reset_L)
    (VC0_rd ^ VC1_rd) |-> (vc0_delay == VC1_rd));

endmodule
